mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline MEM stage; sits directly downstream of the EX stage and consumes its registered outputs
//  (write_reg, mem_to_reg, write_mem, memc, alu_result, des_r, write_mem_val).
//  Performs byte/half/word loads and stores over a req/ack data-memory port.
//  Returns load data sign- or zero-extended; forwards ALU results otherwise.
//  Drives the WB-stage register and holds the upstream pipeline (stall_o) while a memory access is outstanding.
// PARAMETERS
//  ACK_TIMEOUT  64  Cycles in WAIT with no dmem_ack before the access is aborted with err_o (0 = never abort).
// PORTS
//  clk            in   1   Clock, rising edge.
//  rst            in   1   Asynchronous reset, active-high.
//  mem_write_reg  in   1   EX: instruction writes a register.
//  mem_mem_to_reg in   1   EX: register data comes from memory (load).
//  mem_write_mem  in   1   EX: instruction writes memory (store).
//  mem_memc       in   `MEMBus       EX: access type (MEM_LB/LBU/LH/LHU/LW/SB/SH/SW).
//  alu_result     in   `RegDataBus   EX: ALU result; also the byte address for loads and stores.
//  e_des_r        in   `RegAddrBus   EX: destination register.
//  write_mem_val  in   `RegDataBus   EX: store data (unaligned, in the low bits).
//  stall_o        out  1   High while a memory access is in flight; upstream stages hold.
//  dmem_req       out  1   Memory request; held until dmem_ack.
//  dmem_we        out  1   1 = write.
//  dmem_addr      out  `RegDataBus   Word address: {alu_result[31:2], 2'b00}.
//  dmem_be        out  4   Byte enables.
//  dmem_wdata     out  `RegDataBus   Store data, replicated onto the selected byte lanes.
//  dmem_ack       in   1   Memory completes the access (1-cycle pulse).
//  dmem_rdata     in   `RegDataBus   Read word; valid in the dmem_ack cycle.
//  wb_write_reg   out  1   WB: register write enable.
//  wb_des_r       out  `RegAddrBus   WB: destination register.
//  wb_data        out  `RegDataBus   WB: write data.
//  err_o          out  1   1-cycle pulse on a misaligned access or a timeout.
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; the timeout counter is 0.
//    Asserting rst mid-access drops dmem_req in the same cycle (asynchronously).
//  - FSM states: IDLE and WAIT.
//  - IDLE, non-memory op (mem_to_reg = 0 and write_mem = 0):
//    next edge loads wb_data = alu_result, wb_des_r = e_des_r, wb_write_reg = mem_write_reg. Latency 1.
//  - IDLE, load or store:
//    - Alignment check: half needs addr[0] = 0; word needs addr[1:0] = 0.
//    - Aligned: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered; FSM -> WAIT;
//      the type, byte offset and des_r are latched; stall_o = 1 combinationally from entry to WAIT.
//    - Misaligned: no request is issued, err_o pulses, wb_write_reg = 0. Latency 1.
//  - Byte enables: SB -> 4'b0001 << addr[1:0]; SH -> 4'b0011 << addr[1:0]; SW -> 4'b1111.
//  - WAIT: all dmem_* outputs are held stable and wb_write_reg = 0 (bubble). On dmem_ack:
//    - drop dmem_req;
//    - for a load, register wb_data = extend(dmem_rdata lane), wb_write_reg = 1;
//    - for a store, wb_write_reg = 0;
//    - FSM -> IDLE; stall_o falls in the cycle after ack.
//  - Timeout: the counter increments in WAIT. When it reaches ACK_TIMEOUT-1 with no ack:
//    abort, err_o pulses, FSM -> IDLE, no register write.
//  - Load extension:
//    - LB and LH sign-extend bit 7 / bit 15 of the lane.
//    - LBU and LHU zero-extend.
//    - LW passes the word through.
//  - A destination of r0 forces wb_write_reg = 0.
//  - An ack seen in IDLE (spurious) is ignored.
//  - While stall_o = 1, EX inputs are don't-care. Upstream guarantees they are held.
// STRUCTURE
//  - Shared constants in macros.v: MEM_* encodings, `MEMBus, STATE_IDLE/STATE_WAIT.
//  - One sub-module, mem_align (combinational):
//    - store path: {memc, addr[1:0], wdata} -> {be, lane-replicated wdata};
//    - load path: {memc, offset, rdata} -> extended load data.
//  - mem_stage holds the FSM, the timeout counter and the output registers.
// TESTING
//  1. ADD result 32'h0000_1234, des = 5, write_reg = 1
//     -> next cycle wb_data = 32'h1234, wb_des_r = 5, wb_write_reg = 1, dmem_req stays 0.
//  2. SB addr 32'h103, data 32'hA5; ack after 3 cycles
//     -> dmem_addr = 32'h100, be = 4'b1000, wdata = 32'hA5A5A5A5; stall_o high 4 cycles; no WB write.
//  3. LB addr 32'h102, rdata 32'h0080_0000 -> wb_data = 32'hFFFF_FF80.
//     LBU at the same address -> wb_data = 32'h0000_0080.
//  4. LH addr 32'h101 -> no dmem_req, err_o 1-cycle pulse, wb_write_reg = 0.
//     LW addr 32'h102 -> same result.
//  5. LW with ack never asserted, ACK_TIMEOUT = 8
//     -> dmem_req drops after 8 WAIT cycles, err_o pulses, FSM back to IDLE.
//  6. rst asserted during WAIT -> dmem_req = 0 immediately; all outputs 0; a following ADD completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LBU = 3'd1,
    MEM_LH  = 3'd2,
    MEM_LHU = 3'd3,
    MEM_LW  = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } memc_e;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } state_e;

  // Halves need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input memc_e m, input logic [1:0] off);
    case (m)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering: store byte enables/replication and load extraction/extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  memc_e             st_memc,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  memc_e             ld_memc,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_memc)
      MEM_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane    = ld_rdata >> {ld_off, 3'b000};
    ld_data = ld_rdata;
    case (ld_memc)
      MEM_LB:  ld_data = {{24{lane[7]}}, lane[7:0]};
      MEM_LBU: ld_data = {24'h0, lane[7:0]};
      MEM_LH:  ld_data = {{16{lane[15]}}, lane[15:0]};
      MEM_LHU: ld_data = {16'h0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack port, stalls upstream while waiting,
// and registers the write-back data, destination and enable.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write_reg,
  input  logic              mem_mem_to_reg,
  input  logic              mem_write_mem,
  input  memc_e             mem_memc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_W-1:0]  e_des_r,
  input  logic [DATA_W-1:0] write_mem_val,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_write_reg,
  output logic [REG_W-1:0]  wb_des_r,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  memc_e             memc_q, memc_d;
  logic [1:0]        off_q, off_d;
  logic [REG_W-1:0]  des_q, des_d;
  logic              load_q, load_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d, wbw_q, wbw_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, wbd_q, wbd_d;
  logic [3:0]        be_q, be_d;
  logic [REG_W-1:0]  wbr_q, wbr_d;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic              mem_op;

  mem_align u_align (
    .st_memc  (mem_memc),
    .st_off   (alu_result[1:0]),
    .st_data  (write_mem_val),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_memc  (memc_q),
    .ld_off   (off_q),
    .ld_rdata (dmem_rdata),
    .ld_data  (ld_data)
  );

  assign mem_op = mem_mem_to_reg | mem_write_mem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    memc_d  = memc_q;
    off_d   = off_q;
    des_d   = des_q;
    load_d  = load_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wbd_d   = wbd_q;
    wbr_d   = wbr_q;
    wbw_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        cnt_d = '0;
        if (!mem_op) begin
          wbd_d = alu_result;
          wbr_d = e_des_r;
          wbw_d = mem_write_reg && (e_des_r != '0);
        end else if (is_misaligned(mem_memc, alu_result[1:0])) begin
          err_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          we_d    = mem_write_mem;
          addr_d  = {alu_result[DATA_W-1:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_wdata;
          memc_d  = mem_memc;
          off_d   = alu_result[1:0];
          des_d   = e_des_r;
          load_d  = mem_mem_to_reg & ~mem_write_mem;
          state_d = STATE_WAIT;
        end
      end
      STATE_WAIT: begin
        // An ack arriving in the last allowed cycle still completes the access.
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = STATE_IDLE;
          if (load_q) begin
            wbd_d = ld_data;
            wbr_d = des_q;
            wbw_d = des_q != '0;
          end
        end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = STATE_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      memc_q  <= MEM_LB;
      off_q   <= '0;
      des_q   <= '0;
      load_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wbd_q   <= '0;
      wbr_q   <= '0;
      wbw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      memc_q  <= memc_d;
      off_q   <= off_d;
      des_q   <= des_d;
      load_q  <= load_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wbd_q   <= wbd_d;
      wbr_q   <= wbr_d;
      wbw_q   <= wbw_d;
      err_q   <= err_d;
    end
  end

  assign stall_o      = state_q == STATE_WAIT;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_write_reg = wbw_q;
  assign wb_des_r     = wbr_q;
  assign wb_data      = wbd_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB/error events, a monitor pops and compares.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst;
  logic        mem_write_reg, mem_mem_to_reg, mem_write_mem;
  memc_e       mem_memc;
  logic [31:0] alu_result, write_mem_val;
  logic [4:0]  e_des_r;
  logic        stall_o, dmem_req, dmem_we, dmem_ack, wb_write_reg, err_o;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_des_r;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [4:0]  des;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int seen;

  mem_stage #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_write_reg(mem_write_reg), .mem_mem_to_reg(mem_mem_to_reg), .mem_write_mem(mem_write_mem),
    .mem_memc(mem_memc), .alu_result(alu_result), .e_des_r(e_des_r), .write_mem_val(write_mem_val),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_write_reg(wb_write_reg), .wb_des_r(wb_des_r), .wb_data(wb_data), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (wb_write_reg || err_o)) begin
      $display("txn wb_we=%0b err=%0b des=%0d data=%h", wb_write_reg, err_o, wb_des_r, wb_data);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual we=%0b err=%0b data=%h required=no event",
                 wb_write_reg, err_o, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("err_o", {31'b0, err_o}, {31'b0, e.is_err});
        if (e.is_err) begin
          chk("wb_we_on_err", {31'b0, wb_write_reg}, 32'd0);
        end else begin
          chk("wb_write_reg", {31'b0, wb_write_reg}, 32'd1);
          chk("wb_data", wb_data, e.data);
          chk("wb_des_r", {27'b0, wb_des_r}, {27'b0, e.des});
        end
      end
    end
  end

  task automatic nop();
    mem_write_reg  = 1'b0;
    mem_mem_to_reg = 1'b0;
    mem_write_mem  = 1'b0;
    mem_memc       = MEM_LB;
    alu_result     = 32'h0;
    e_des_r        = 5'd0;
    write_mem_val  = 32'h0;
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic [4:0] r);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.des = r;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.data = 32'h0; e.des = 5'd0;
    exp_q.push_back(e);
  endtask

  task automatic issue_alu(input logic [31:0] res, input logic [4:0] des, input logic wr);
    mem_write_reg = wr;
    alu_result    = res;
    e_des_r       = des;
    @(posedge clk); #1;
    nop();
  endtask

  task automatic issue_mem(input memc_e m, input logic st, input logic [31:0] addr,
                           input logic [31:0] wv, input logic [4:0] des);
    mem_memc       = m;
    mem_write_mem  = st;
    mem_mem_to_reg = ~st;
    mem_write_reg  = ~st;
    alu_result     = addr;
    write_mem_val  = wv;
    e_des_r        = des;
    @(posedge clk); #1;
    nop();
  endtask

  // Holds ack low for n cycles, then pulses it with rd; returns how many cycles stall_o was seen high.
  task automatic ack_after(input int n, input logic [31:0] rd, output int stall_seen);
    stall_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall_o) stall_seen++;
      @(posedge clk); #1;
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rd;
    @(negedge clk);
    if (stall_o) stall_seen++;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    chk({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_be"}, {28'b0, dmem_be}, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_wb_we"}, {31'b0, wb_write_reg}, 32'd0);
    chk({tag, "_wb_des"}, {27'b0, wb_des_r}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_err"}, {31'b0, err_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU forwarding, r0 suppression and write_reg=0
    expect_wb(32'h0000_1234, 5'd5);
    issue_alu(32'h0000_1234, 5'd5, 1'b1);
    chk("alu_no_req", {31'b0, dmem_req}, 32'd0);
    issue_alu(32'hFFFF_0000, 5'd0, 1'b1);
    issue_alu(32'h0000_0042, 5'd9, 1'b0);

    // SB at 0x103, ack after 3 cycles
    $display("txn issue SB addr=00000103");
    issue_mem(MEM_SB, 1'b1, 32'h103, 32'hA5, 5'd0);
    chk("sb_req", {31'b0, dmem_req}, 32'd1);
    chk("sb_we", {31'b0, dmem_we}, 32'd1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", {28'b0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    ack_after(3, 32'h0, seen);
    chk("sb_stall_cycles", seen, 32'd4);
    chk("sb_req_dropped", {31'b0, dmem_req}, 32'd0);
    chk("sb_stall_low", {31'b0, stall_o}, 32'd0);

    // Loads with extension
    expect_wb(32'hFFFF_FF80, 5'd7);
    issue_mem(MEM_LB, 1'b0, 32'h102, 32'h0, 5'd7);
    chk("lb_req", {31'b0, dmem_req}, 32'd1);
    chk("lb_we", {31'b0, dmem_we}, 32'd0);
    chk("lb_addr", dmem_addr, 32'h100);
    ack_after(1, 32'h0080_0000, seen);
    expect_wb(32'h0000_0080, 5'd8);
    issue_mem(MEM_LBU, 1'b0, 32'h102, 32'h0, 5'd8);
    ack_after(0, 32'h0080_0000, seen);
    expect_wb(32'hFFFF_8001, 5'd9);
    issue_mem(MEM_LH, 1'b0, 32'h102, 32'h0, 5'd9);
    ack_after(2, 32'h8001_0000, seen);
    expect_wb(32'h0000_8001, 5'd10);
    issue_mem(MEM_LHU, 1'b0, 32'h102, 32'h0, 5'd10);
    ack_after(0, 32'h8001_0000, seen);
    expect_wb(32'hDEAD_BEEF, 5'd11);
    issue_mem(MEM_LW, 1'b0, 32'h100, 32'h0, 5'd11);
    ack_after(1, 32'hDEAD_BEEF, seen);
    issue_mem(MEM_LB, 1'b0, 32'h101, 32'h0, 5'd0);
    ack_after(0, 32'h0000_7700, seen);

    // SH and SW lane steering
    issue_mem(MEM_SH, 1'b1, 32'h102, 32'h0000_1234, 5'd0);
    chk("sh_be", {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    ack_after(0, 32'h0, seen);
    issue_mem(MEM_SW, 1'b1, 32'h104, 32'hCAFE_F00D, 5'd0);
    chk("sw_addr", dmem_addr, 32'h104);
    chk("sw_be", {28'b0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    ack_after(1, 32'h0, seen);

    // Misaligned accesses
    expect_err();
    issue_mem(MEM_LH, 1'b0, 32'h101, 32'h0, 5'd12);
    chk("lh_mis_no_req", {31'b0, dmem_req}, 32'd0);
    chk("lh_mis_no_stall", {31'b0, stall_o}, 32'd0);
    expect_err();
    issue_mem(MEM_LW, 1'b0, 32'h102, 32'h0, 5'd13);
    chk("lw_mis_no_req", {31'b0, dmem_req}, 32'd0);

    // Spurious ack in IDLE
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    chk("spurious_no_stall", {31'b0, stall_o}, 32'd0);

    // Timeout
    expect_err();
    issue_mem(MEM_LW, 1'b0, 32'h200, 32'h0, 5'd3);
    seen = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      @(negedge clk);
      if (dmem_req) seen++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", seen, 32'd8);
    chk("timeout_idle", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;

    // Async reset during WAIT
    issue_mem(MEM_LW, 1'b0, 32'h300, 32'h0, 5'd4);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_wb(32'h0000_0055, 5'd6);
    issue_alu(32'h0000_0055, 5'd6, 1'b1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
